// File: rtl/klingon_b.sv
// klingon_b: registered 7-segment decoder for the "Klingon" numeral style,
// variant b. Maps a 4-bit digit code to a fixed custom glyph. The output is
// registered, so the segment lines change only on clock edges and cannot
// glitch.
//
// Ports:
//   clk    in   1  system clock, rising edge
//   reset  in   1  synchronous, active-high; blanks the display (out = 7'h00)
//   in     in   4  digit code; 0-9 valid, 10-15 show the error glyph
//   out    out  7  segments, active-high: out[6]=a b c d e f out[0]=g
module klingon_b (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] in,
  output logic [6:0] out
);

  logic [6:0] glyph;
  logic [6:0] out_d;
  logic [6:0] out_q;

  // Full case with a default, so the decode stays combinational for every
  // code. Codes 10-15 all share the three-bar error glyph (a, d, g).
  always_comb begin
    glyph = 7'h49;
    unique case (in)
      4'd0:    glyph = 7'h1D;
      4'd1:    glyph = 7'h30;
      4'd2:    glyph = 7'h36;
      4'd3:    glyph = 7'h79;
      4'd4:    glyph = 7'h4E;
      4'd5:    glyph = 7'h5B;
      4'd6:    glyph = 7'h67;
      4'd7:    glyph = 7'h0F;
      4'd8:    glyph = 7'h7E;
      4'd9:    glyph = 7'h3F;
      default: glyph = 7'h49;
    endcase
  end

  // Reset takes priority over the decoded glyph on the same edge.
  always_comb begin
    out_d = glyph;
    if (reset) begin
      out_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    out_q <= out_d;
  end

  assign out = out_q;

endmodule

// File: tb/tb_klingon_b.sv
module tb_klingon_b;

  logic       clk;
  logic       reset;
  logic [3:0] in;
  logic [6:0] out;

  klingon_b dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] exp;
    string      name;
  } exp_t;

  exp_t q[$];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned n_pushed = 0;
  int unsigned n_popped = 0;

  // Hand-written glyph table (codes 0-9), error glyph for 10-15.
  logic [6:0] glyph_tab [0:9] = '{7'h1D, 7'h30, 7'h36, 7'h79, 7'h4E,
                                  7'h5B, 7'h67, 7'h0F, 7'h7E, 7'h3F};

  function automatic logic [6:0] model(input logic [3:0] code, input logic rst);
    if (rst) return 7'h00;
    if (code > 4'd9) return 7'h49;
    return glyph_tab[code];
  endfunction

  logic       have_prev = 1'b0;
  logic [6:0] prev_exp  = '0;

  // Drive one code/reset pair at the falling edge; the next rising edge
  // captures it. Also checks out has not moved yet in the same cycle.
  task automatic step(input logic [3:0] code, input logic rst, input string name);
    exp_t e;
    @(negedge clk);
    in    = code;
    reset = rst;
    e.exp  = model(code, rst);
    e.name = name;
    q.push_back(e);
    n_pushed++;
    #1;
    if (have_prev) begin
      n_tests++;
      if (out !== prev_exp) begin
        n_fail++;
        $display("FAIL latency[%s]: out=%h expected still %h", name, out, prev_exp);
      end
    end
    prev_exp  = e.exp;
    have_prev = 1'b1;
  endtask

  // Monitor: every rising edge presents a new registered output.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_popped++;
        n_tests++;
        if (out !== e.exp) begin
          n_fail++;
          $display("FAIL %s: out=%h expected %h", e.name, out, e.exp);
        end
      end
    end
  end

  initial begin
    int unsigned budget;
    in    = 4'd5;
    reset = 1'b1;

    // Reset held for three edges with in=5, then release.
    for (int i = 0; i < 3; i++) step(4'd5, 1'b1, "reset_hold");
    step(4'd5, 1'b0, "reset_release");

    // Full valid sweep.
    for (int i = 0; i < 10; i++) step(4'(i), 1'b0, "sweep");

    // Invalid codes, then recovery.
    for (int i = 10; i < 16; i++) step(4'(i), 1'b0, "invalid");
    step(4'd8, 1'b0, "recover");

    // Reset mid-stream.
    step(4'd1, 1'b0, "midrst_1");
    step(4'd2, 1'b0, "midrst_2");
    step(4'd3, 1'b1, "midrst_blank");
    step(4'd4, 1'b0, "midrst_after");

    // Hold constant.
    for (int i = 0; i < 10; i++) step(4'd7, 1'b0, "hold7");

    // Alternating extremes.
    for (int i = 0; i < 8; i++) step((i % 2 == 0) ? 4'd0 : 4'd15, 1'b0, "alt");

    // Drain the scoreboard with a bounded wait.
    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      @(posedge clk);
      #2;
      budget++;
    end
    n_tests++;
    if (q.size() != 0 || n_popped != n_pushed) begin
      n_fail++;
      $display("FAIL drain: popped=%0d expected %0d", n_popped, n_pushed);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/klingon_b.md
Name: klingon_b

Overview:
- Registered decoder that converts a 4-bit digit code (0-9) into a 7-segment glyph pattern for the "Klingon" numeral style, variant b.
- Sits between the digit source and the segment driver of the display path.
- Each digit gets a fixed custom glyph. Codes 10-15 show an error glyph.
- One clock of latency. The output is held in a register so segment lines never glitch.

Parameters:
- none (glyph table is fixed; no build-time options)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- in  input  4  digit code, unsigned; 0-9 valid, 10-15 invalid
- out  output  7  segment pattern, active-high (1 = segment lit); out[6]=a, out[5]=b, out[4]=c, out[3]=d, out[2]=e, out[1]=f, out[0]=g

Behaviour:
- Clocking: one clock (clk). Reset is synchronous and active-high. No other clocks, no asynchronous paths to out.
- out is a register. There is no combinational path from in to out.
- Reset:
  - on a rising edge with reset=1, out <= 7'h00 (all segments dark), regardless of in.
  - reset has priority over decode on the same edge.
  - reset held for multiple cycles keeps out at 7'h00.
- Normal operation: on each rising edge with reset=0, out <= glyph(in), where in is the value sampled at that edge.
- Latency: exactly 1 cycle from in to out. A new code every cycle gives a new glyph every cycle (throughput 1/cycle).
- Glyph table (in -> out, hex):
  - 0 -> 1D
  - 1 -> 30
  - 2 -> 36
  - 3 -> 79
  - 4 -> 4E
  - 5 -> 5B
  - 6 -> 67
  - 7 -> 0F
  - 8 -> 7E
  - 9 -> 3F
- All ten valid glyphs are mutually distinct and nonzero, so blank (00) is unambiguous as the reset/idle state.
- Invalid codes 10-15 (A-F): out <= 7'h49 (segments a, d, g: three horizontal bars = error). The same glyph is used for all six codes.
- X/Z on in: behaviour is not required. Simulation may propagate X. No lint-visible latches are allowed: the decode must be a full case with a default.
- Reset mid-operation: asserting reset while codes are streaming blanks out on that edge. After deassertion, the first edge with reset=0 loads glyph(in). No stale glyph reappears.
- Holding in constant holds out constant (idempotent re-registration, no toggling).
- Power-up before the first reset: out is undefined. The system is required to apply reset at least one cycle before use.

Test Plan:
- Reset: set in=5 and hold reset=1 for 3 edges -> out=00 after each edge. Deassert reset -> next edge out=5B.
- Full sweep: with reset=0, apply in=0..9, one per cycle -> out follows the glyph table one cycle later. Sequence is 1D, 30, 36, 79, 4E, 5B, 67, 0F, 7E, 3F. Also check that out has not yet changed in the same cycle in changes (1-cycle latency).
- Invalid codes: apply in=10..15 -> out=49 one cycle after each. Then in=8 -> out=7E, confirming recovery from the error glyph.
- Reset mid-stream: stream in=1,2,3 and assert reset on the edge where 3 is sampled -> out=00 (not 79). Deassert with in=4 -> next edge out=4E.
- Hold/stability: keep in=7 for 10 cycles -> out=0F on every cycle after the first, with no intermediate values.
- Back-to-back extremes: alternate in=0 and in=15 every cycle for 8 cycles -> out alternates 1D/49, delayed by one cycle.
